// File: rtl/trng_sequencer.sv
// trng_sequencer
//   Sequences the SR-latch entropy network: pulses latch_en, waits a settle
//   window, samples latch_bit, von Neumann debiases raw bit pairs and packs
//   the surviving bits (oldest in MSB) into WIDTH-bit words. Also runs a
//   repetition-count health test on the raw stream.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous reset, active-high
//   run          level; 1 = keep generating words
//   latch_en     one-cycle enable pulse to the latch network
//   latch_bit    registered, XOR-reduced bit from the latch network
//   rnd_data     output word, stable while rnd_valid=1
//   rnd_valid    output word available
//   rnd_ready    consumer accepts when rnd_valid & rnd_ready
//   health_fail  sticky repetition-test failure
//   busy         1 in any state other than IDLE
module trng_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int REP_LIMIT     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             latch_en,
  input  logic             latch_bit,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             health_fail,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int REP_W = 8;

  typedef enum logic [1:0] {IDLE, ARM, SETTLE, SAMPLE} state_t;

  state_t           state;
  logic [SET_W-1:0] settle_cnt;
  logic [WIDTH-1:0] shift;
  logic [CNT_W-1:0] count;
  logic             have_first;
  logic             first_bit;
  logic             last_raw;
  logic [REP_W-1:0] rep;   // 0 means no raw sample seen since reset

  // Post-sample values of the datapath registers
  logic [WIDTH-1:0] shift_n;
  logic [CNT_W-1:0] count_n;
  logic             have_first_n;
  logic             first_n;
  logic             last_raw_n;
  logic [REP_W-1:0] rep_n;
  logic             fail_n;
  logic             full_n;
  logic             xfer;
  logic             go;

  function automatic logic [REP_W-1:0] rep_sat_inc(input logic [REP_W-1:0] r);
    if (r >= REP_W'(REP_LIMIT)) return REP_W'(REP_LIMIT);
    return r + 1'b1;
  endfunction

  always_comb begin
    shift_n      = shift;
    count_n      = count;
    have_first_n = have_first;
    first_n      = first_bit;
    last_raw_n   = last_raw;
    rep_n        = rep;
    fail_n       = health_fail;
    if (state == SAMPLE) begin
      last_raw_n = latch_bit;
      if ((rep != '0) && (latch_bit == last_raw)) rep_n = rep_sat_inc(rep);
      else                                         rep_n = REP_W'(1);
      if (rep_n == REP_W'(REP_LIMIT)) fail_n = 1'b1;
      // The tripping sample itself is not debiased
      if (!fail_n) begin
        if (!have_first) begin
          first_n      = latch_bit;
          have_first_n = 1'b1;
        end else begin
          have_first_n = 1'b0;
          if (latch_bit != first_bit) begin
            shift_n = {shift[WIDTH-2:0], first_bit};
            count_n = count + CNT_W'(1);
          end
        end
      end
    end
    full_n = (count_n == CNT_W'(WIDTH));
    // Transfer can happen on the very edge that completes the word
    xfer   = full_n && (!rnd_valid || rnd_ready);
    // A full shift register that cannot drain blocks further trials
    go     = run && !fail_n && !(full_n && !xfer);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      latch_en    <= 1'b0;
      settle_cnt  <= '0;
      shift       <= '0;
      count       <= '0;
      have_first  <= 1'b0;
      first_bit   <= 1'b0;
      last_raw    <= 1'b0;
      rep         <= '0;
      health_fail <= 1'b0;
      rnd_data    <= '0;
      rnd_valid   <= 1'b0;
    end else begin
      shift       <= shift_n;
      have_first  <= have_first_n;
      first_bit   <= first_n;
      last_raw    <= last_raw_n;
      rep         <= rep_n;
      health_fail <= fail_n;

      if (xfer) begin
        rnd_data  <= shift_n;
        rnd_valid <= 1'b1;
        count     <= '0;
      end else begin
        count <= count_n;
        if (rnd_valid && rnd_ready) rnd_valid <= 1'b0;
      end

      latch_en <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state    <= ARM;
            latch_en <= 1'b1;
          end
        end
        ARM: begin
          state      <= SETTLE;
          settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= SAMPLE;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        SAMPLE: begin
          if (go) begin
            state    <= ARM;
            latch_en <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_sequencer.sv
module tb_trng_sequencer;

  localparam int WIDTH     = 8;
  localparam int SETTLE    = 4;
  localparam int REP_LIMIT = 16;
  localparam int PERIOD    = SETTLE + 2;

  logic             clk = 1'b0;
  logic             rst, run, latch_en, latch_bit, rnd_valid, rnd_ready;
  logic             health_fail, busy;
  logic [WIDTH-1:0] rnd_data;

  always #5 clk = ~clk;

  trng_sequencer #(
    .WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .REP_LIMIT(REP_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .latch_en(latch_en),
    .latch_bit(latch_bit), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .health_fail(health_fail), .busy(busy)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: trial phase counter (-1 idle, 0 pulse, SETTLE+1 sample),
  // a queue of debiased bits, and the output word register.
  int               m_phase;
  bit               m_hf;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  bit               m_bits[$];
  int               m_first;   // -1 when no first bit of a pair is held
  int               m_last;    // -1 when no raw sample seen yet
  int               m_rep;

  typedef struct {
    logic [19:0]      raw;
    int               n;
    logic [WIDTH-1:0] exp;
  } vec_t;
  vec_t tbl[5];

  logic [WIDTH-1:0] w1, w2, w3;
  int               pulses;
  bit               ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = -1; m_hf = 0; m_valid = 0; m_data = '0;
    m_bits.delete(); m_first = -1; m_last = -1; m_rep = 0;
  endfunction

  task automatic model_step();
    int raw;
    bit full;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_phase == SETTLE + 1) begin
      raw = int'(latch_bit);
      if (m_last == raw) m_rep = (m_rep < REP_LIMIT) ? m_rep + 1 : m_rep;
      else               m_rep = 1;
      m_last = raw;
      if (m_rep >= REP_LIMIT) m_hf = 1;
      if (!m_hf) begin
        if (m_first < 0) m_first = raw;
        else begin
          if (raw != m_first) m_bits.push_back(m_first[0]);
          m_first = -1;
        end
      end
    end
    full = (m_bits.size() == WIDTH);
    if (full && (!m_valid || rnd_ready)) begin
      m_data = '0;
      foreach (m_bits[i]) m_data = {m_data[WIDTH-2:0], m_bits[i]};
      m_valid = 1;
      m_bits.delete();
      full = 0;
    end else if (m_valid && rnd_ready) begin
      m_valid = 0;
    end
    if (m_phase < 0 || m_phase == SETTLE + 1) m_phase = (run && !m_hf && !full) ? 0 : -1;
    else                                       m_phase = m_phase + 1;
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("latch_en",    32'(latch_en),    32'(m_phase == 0));
    chk("busy",        32'(busy),        32'(m_phase >= 0));
    chk("rnd_valid",   32'(rnd_valid),   32'(m_valid));
    chk("health_fail", 32'(health_fail), 32'(m_hf));
    chk("rnd_data",    32'(rnd_data),    32'(m_data));
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; rnd_ready = 1'b0; latch_bit = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  task automatic wait_pulse(output bit got);
    got = 0;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      cyc();
      if (latch_en === 1'b1) begin
        got = 1;
        return;
      end
    end
    nvec++;
    nerr++;
    $display("FAIL pulse_timeout: no latch_en within %0d cycles (t=%0t)", 4 * PERIOD, $time);
  endtask

  // Each pair is b followed by ~b, so every pair yields exactly the bit b
  task automatic feed_pairs(input int n, output logic [WIDTH-1:0] w);
    bit b;
    bit g;
    w = '0;
    for (int p = 0; p < n; p++) begin
      b = 1'($urandom_range(0, 1));
      w = {w[WIDTH-2:0], b};
      for (int k = 0; k < 2; k++) begin
        wait_pulse(g);
        if (!g) return;
        latch_bit = (k == 1) ? ~b : b;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{20'h93969, 20, 8'hA6};  // 10,01,00,11,10,01,01,10,10,01
    tbl[1] = '{20'h0AAAA, 16, 8'hFF};
    tbl[2] = '{20'h05555, 16, 8'h00};
    tbl[3] = '{20'h09999, 16, 8'hAA};
    tbl[4] = '{20'hE8659, 20, 8'hD2};  // 11,10,10,00,01,10,01,01,10,01

    // Reset and idle
    do_reset();
    chk("rst_latch_en",    32'(latch_en),    32'd0);
    chk("rst_rnd_data",    32'(rnd_data),    32'd0);
    chk("rst_rnd_valid",   32'(rnd_valid),   32'd0);
    chk("rst_health_fail", 32'(health_fail), 32'd0);
    chk("rst_busy",        32'(busy),        32'd0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      latch_bit = 1'($urandom_range(0, 1));
      cyc();
      if (latch_en) pulses++;
    end
    chk("idle_pulses", 32'(pulses), 32'd0);

    // Trial timing
    run = 1'b1; latch_bit = 1'b0;
    cyc();
    chk("first_pulse", 32'(latch_en), 32'd1);
    for (int j = 1; j <= 4 * PERIOD; j++) begin
      cyc();
      chk("pulse_period", 32'(latch_en), 32'((j % PERIOD) == 0));
    end

    // Table-driven debias/packing vectors
    for (int t = 0; t < 5; t++) begin
      do_reset();
      run = 1'b1;
      ok = 1;
      for (int i = 0; i < tbl[t].n && ok; i++) begin
        wait_pulse(ok);
        latch_bit = tbl[t].raw[tbl[t].n - 1 - i];
        if (i == tbl[t].n - 1) run = 1'b0;
      end
      repeat (SETTLE + 1) cyc();
      chk("tbl_early_valid", 32'(rnd_valid), 32'd0);
      cyc();
      chk("tbl_valid", 32'(rnd_valid), 32'd1);
      chk("tbl_word",  32'(rnd_data),  32'(tbl[t].exp));
    end

    // Backpressure: two words stored, trials stop until the consumer accepts
    do_reset();
    run = 1'b1;
    feed_pairs(WIDTH, w1);
    feed_pairs(WIDTH, w2);
    repeat (PERIOD + 2) cyc();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (latch_en) pulses++;
    end
    chk("bp_no_pulse", 32'(pulses),    32'd0);
    chk("bp_busy",     32'(busy),      32'd0);
    chk("bp_valid",    32'(rnd_valid), 32'd1);
    chk("bp_word1",    32'(rnd_data),  32'(w1));
    rnd_ready = 1'b1;
    cyc();
    rnd_ready = 1'b0;
    chk("bp_valid_hold", 32'(rnd_valid), 32'd1);
    chk("bp_word2",      32'(rnd_data),  32'(w2));
    chk("bp_resume",     32'(latch_en),  32'd1);

    // Health test: stuck-at-1 raw stream
    do_reset();
    run = 1'b1; latch_bit = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20 * PERIOD; i++) begin
      cyc();
      if (latch_en) pulses++;
      if (health_fail) break;
    end
    chk("hf_set",    32'(health_fail), 32'd1);
    chk("hf_trials", 32'(pulses),      32'(REP_LIMIT));
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (latch_en) pulses++;
    end
    chk("hf_no_pulse", 32'(pulses),    32'd0);
    chk("hf_busy",     32'(busy),      32'd0);
    chk("hf_valid",    32'(rnd_valid), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("hf_clear", 32'(health_fail), 32'd0);

    // run dropped during SETTLE: current trial completes, then IDLE
    do_reset();
    run = 1'b1; latch_bit = 1'b1;
    wait_pulse(ok);
    cyc(); cyc();
    run = 1'b0;
    repeat (3) cyc();
    chk("drop_sample_busy", 32'(busy), 32'd1);
    cyc();
    chk("drop_idle_busy",  32'(busy),     32'd0);
    chk("drop_no_pulse",   32'(latch_en), 32'd0);

    // rst during SETTLE with a pending word and a partial word
    do_reset();
    run = 1'b1;
    feed_pairs(WIDTH + 3, w1);
    wait_pulse(ok);
    cyc(); cyc();
    chk("pre_rst_valid", 32'(rnd_valid), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_busy",     32'(busy),      32'd0);
    chk("mid_rst_latch_en", 32'(latch_en),  32'd0);
    chk("mid_rst_valid",    32'(rnd_valid), 32'd0);
    chk("mid_rst_data",     32'(rnd_data),  32'd0);
    feed_pairs(WIDTH, w3);
    run = 1'b0;
    repeat (SETTLE + 2) cyc();
    chk("post_rst_valid", 32'(rnd_valid), 32'd1);
    chk("post_rst_word",  32'(rnd_data),  32'(w3));

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      rst       = ($urandom_range(0, 999) == 0);
      run       = ($urandom_range(0, 9) != 0);
      rnd_ready = (i < 3000) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      latch_bit = (i < 2000) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
